// File: rtl/lcd_arb_pkg.sv
// lcd_arb_pkg: shared types and init command table for the LCD write arbiter.
// States, init sequence length/commands and the requester port index type.
package lcd_arb_pkg;

    typedef enum logic [1:0] {
        WAIT_PWR,
        INIT_WR,
        IDLE,
        WRITE
    } state_t;

    localparam int INIT_LEN = 5;
    localparam int IDX_W    = $clog2(INIT_LEN);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic             port_t;

    // Element 0 is issued first: function set, display off, clear,
    // entry mode, display on.
    localparam logic [INIT_LEN-1:0][7:0] INIT_CMD = {
        8'h0C, 8'h06, 8'h01, 8'h08, 8'h38
    };

    function automatic logic [7:0] init_cmd(idx_t i);
        return (int'(i) < INIT_LEN) ? INIT_CMD[i] : 8'h00;
    endfunction

endpackage

// File: rtl/lcd_write_timer.sv
// lcd_write_timer: one LCD write cycle of T_CYC clocks, E high for first half.
// start is held high for as long as back-to-back cycles should run.
module lcd_write_timer #(
    parameter int T_CYC = 100_000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic start,
    output logic lcd_e,
    output logic done
);

    localparam int            TW     = $clog2(T_CYC);
    localparam logic [TW-1:0] T_LAST = TW'(T_CYC - 1);
    localparam logic [TW-1:0] T_HALF = TW'(T_CYC / 2);

    logic [TW-1:0] t;

    assign done  = start && (t == T_LAST);
    assign lcd_e = start && (t < T_HALF);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            t <= '0;
        end else if (!start || done) begin
            t <= '0;
        end else begin
            t <= t + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: LCD bus owner with power-up init and round-robin writers.
// Define LCD_ARB_LOCK_EN to let a port hold the bus across a burst via LOCKn.
module lcd_write_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int T_INIT = 1_000_000,
    parameter int T_CYC  = 100_000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ0,
    input  logic       RS0,
    input  logic [7:0] DATA0,
    input  logic       LOCK0,
    output logic       GNT0,
    input  logic       REQ1,
    input  logic       RS1,
    input  logic [7:0] DATA1,
    input  logic       LOCK1,
    output logic       GNT1,
    output logic       BUSY,
    output logic       INIT_DONE,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic [7:0] LCD_DATA
);

    localparam int            PW       = $clog2(T_INIT + 1);
    localparam logic [PW-1:0] PWR_LAST = PW'(T_INIT - 1);
    localparam idx_t          IDX_LAST = idx_t'(INIT_LEN - 1);

    state_t        state, state_nx;
    logic [PW-1:0] pwr_cnt, pwr_nx;
    idx_t          idx, idx_nx;
    logic          init_done_nx;
    logic          rs_nx;
    logic [7:0]    data_nx;
    port_t         win, win_nx;
    port_t         last, last_nx;
    port_t         pick;
    logic          locked;
    logic          lock_act;
    logic          win_lock;
    logic          tmr_start;
    logic          done;

    assign tmr_start = (state == INIT_WR) || (state == WRITE);
    assign BUSY      = (state != IDLE);
    assign win_lock  = win ? LOCK1 : LOCK0;

    lcd_write_timer #(
        .T_CYC (T_CYC)
    ) u_timer (
        .CLK   (CLK),
        .RST_N (RST_N),
        .start (tmr_start),
        .lcd_e (LCD_E),
        .done  (done)
    );

`ifdef LCD_ARB_LOCK_EN
    // Lock is decided by the winner's LOCKn at the moment its write completes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lock_act <= 1'b0;
        end else if (state == WRITE && done) begin
            lock_act <= win_lock;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = win_lock;
    assign lock_act    = 1'b0;
`endif

    always_comb begin
        locked = lock_act && (win ? REQ1 : REQ0);
        pick   = win;
        unique case (1'b1)
            locked:                    pick = win;
            (REQ0 && REQ1 && !locked): pick = ~last;
            default:                   pick = REQ1;
        endcase
    end

    always_comb begin
        state_nx     = state;
        pwr_nx       = pwr_cnt;
        idx_nx       = idx;
        init_done_nx = INIT_DONE;
        rs_nx        = LCD_RS;
        data_nx      = LCD_DATA;
        win_nx       = win;
        last_nx      = last;
        GNT0         = 1'b0;
        GNT1         = 1'b0;
        unique case (state)
            WAIT_PWR: begin
                if (pwr_cnt == PWR_LAST) begin
                    state_nx = INIT_WR;
                    idx_nx   = '0;
                    rs_nx    = 1'b0;
                    data_nx  = init_cmd(idx_t'(0));
                end else begin
                    pwr_nx = pwr_cnt + 1'b1;
                end
            end
            INIT_WR: begin
                if (done) begin
                    if (idx == IDX_LAST) begin
                        state_nx     = IDLE;
                        init_done_nx = 1'b1;
                    end else begin
                        idx_nx  = idx + 1'b1;
                        data_nx = init_cmd(idx_nx);
                    end
                end
            end
            IDLE: begin
                if (REQ0 || REQ1) begin
                    state_nx = WRITE;
                    win_nx   = pick;
                    rs_nx    = pick ? RS1 : RS0;
                    data_nx  = pick ? DATA1 : DATA0;
                    // A locked grant leaves the fairness pointer alone.
                    if (!locked) begin
                        last_nx = pick;
                    end
                end
            end
            WRITE: begin
                if (done) begin
                    state_nx = IDLE;
                    GNT0     = !win;
                    GNT1     = win;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= WAIT_PWR;
            pwr_cnt   <= '0;
            idx       <= '0;
            INIT_DONE <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_DATA  <= 8'h00;
            win       <= 1'b0;
            last      <= 1'b1;
        end else begin
            state     <= state_nx;
            pwr_cnt   <= pwr_nx;
            idx       <= idx_nx;
            INIT_DONE <= init_done_nx;
            LCD_RS    <= rs_nx;
            LCD_DATA  <= data_nx;
            win       <= win_nx;
            last      <= last_nx;
        end
    end

endmodule
